// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - BCD HH:MM:SS countdown timer with load validation and pause/resume
module countdown_timer #(
    parameter int HR_MAX = 23
) (
    input  logic       clk_1hz,
    input  logic       rst,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] set_hrm,
    input  logic [3:0] set_hrl,
    input  logic [3:0] set_minm,
    input  logic [3:0] set_minl,
    input  logic [3:0] set_secm,
    input  logic [3:0] set_secl,
    output logic [3:0] hrm,
    output logic [3:0] hrl,
    output logic [3:0] minm,
    output logic [3:0] minl,
    output logic [3:0] secm,
    output logic [3:0] secl,
    output logic       running,
    output logic       expired,
    output logic       done,
    output logic       load_err
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [7:0] HR_LIMIT = 8'(HR_MAX);

    state_t     state, state_n;
    logic [3:0] hrm_n, hrl_n, minm_n, minl_n, secm_n, secl_n;
    logic [3:0] d_hrm, d_hrl, d_minm, d_minl, d_secm, d_secl;
    logic       b0, b1, b2, b3, b4;
    logic       done_n, load_err_n;
    logic       load_ok, is_zero, dec_zero;
    logic [7:0] set_hours;

    assign set_hours = 8'(set_hrm) * 8'd10 + 8'(set_hrl);
    assign load_ok   = (set_secl <= 4'd9) && (set_secm <= 4'd5) &&
                       (set_minl <= 4'd9) && (set_minm <= 4'd5) &&
                       (set_hrl  <= 4'd9) && (set_hrm  <= 4'd2) &&
                       (set_hours <= HR_LIMIT);

    assign is_zero  = ({hrm, hrl, minm, minl, secm, secl} == 24'd0);
    // Only 00:00:01 decrements into zero.
    assign dec_zero = ({hrm, hrl, minm, minl, secm} == 20'd0) && (secl == 4'd1);

    // Borrow ripples from seconds units upward; each digit wraps to its own maximum.
    assign b0     = (secl == 4'd0);
    assign b1     = b0 && (secm == 4'd0);
    assign b2     = b1 && (minl == 4'd0);
    assign b3     = b2 && (minm == 4'd0);
    assign b4     = b3 && (hrl == 4'd0);
    assign d_secl = b0 ? 4'd9 : secl - 4'd1;
    assign d_secm = b0 ? (b1 ? 4'd5 : secm - 4'd1) : secm;
    assign d_minl = b1 ? (b2 ? 4'd9 : minl - 4'd1) : minl;
    assign d_minm = b2 ? (b3 ? 4'd5 : minm - 4'd1) : minm;
    assign d_hrl  = b3 ? (b4 ? 4'd9 : hrl - 4'd1) : hrl;
    assign d_hrm  = b4 ? hrm - 4'd1 : hrm;

    always_comb begin
        state_n    = state;
        hrm_n      = hrm;
        hrl_n      = hrl;
        minm_n     = minm;
        minl_n     = minl;
        secm_n     = secm;
        secl_n     = secl;
        done_n     = 1'b0;
        load_err_n = 1'b0;
        if (load) begin
            if (load_ok) begin
                state_n = IDLE;
                {hrm_n, hrl_n, minm_n, minl_n, secm_n, secl_n} =
                    {set_hrm, set_hrl, set_minm, set_minl, set_secm, set_secl};
            end else begin
                load_err_n = 1'b1;
            end
        end else if (pause) begin
            if (state == RUN) state_n = PAUSE;
        end else if (state == RUN) begin
            if (is_zero) begin
                state_n = DONE;
            end else begin
                {hrm_n, hrl_n, minm_n, minl_n, secm_n, secl_n} =
                    {d_hrm, d_hrl, d_minm, d_minl, d_secm, d_secl};
                if (dec_zero) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end
            end
        end else if (start) begin
            if ((state == IDLE && !is_zero) || state == PAUSE) state_n = RUN;
        end
    end

    always_ff @(posedge clk_1hz) begin
        if (!rst) begin
            state    <= IDLE;
            {hrm, hrl, minm, minl, secm, secl} <= 24'd0;
            running  <= 1'b0;
            expired  <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_n;
            {hrm, hrl, minm, minl, secm, secl} <=
                {hrm_n, hrl_n, minm_n, minl_n, secm_n, secl_n};
            running  <= (state_n == RUN);
            expired  <= (state_n == DONE);
            done     <= done_n;
            load_err <= load_err_n;
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed scoreboard bench for countdown_timer
module tb_countdown_timer;

    logic       clk_1hz = 1'b0;
    logic       rst, load, start, pause;
    logic [3:0] set_hrm, set_hrl, set_minm, set_minl, set_secm, set_secl;
    logic [3:0] hrm, hrl, minm, minl, secm, secl;
    logic       running, expired, done, load_err;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [23:0] d;
        logic [3:0]  f;
    } exp_t;

    exp_t sb[$];

    countdown_timer #(.HR_MAX(23)) dut (
        .clk_1hz (clk_1hz),
        .rst     (rst),
        .load    (load),
        .start   (start),
        .pause   (pause),
        .set_hrm (set_hrm),
        .set_hrl (set_hrl),
        .set_minm(set_minm),
        .set_minl(set_minl),
        .set_secm(set_secm),
        .set_secl(set_secl),
        .hrm     (hrm),
        .hrl     (hrl),
        .minm    (minm),
        .minl    (minl),
        .secm    (secm),
        .secl    (secl),
        .running (running),
        .expired (expired),
        .done    (done),
        .load_err(load_err)
    );

    always #5 clk_1hz = ~clk_1hz;

    function automatic logic [23:0] bcd(input int s);
        int h, m, c;
        h = s / 3600;
        m = (s / 60) % 60;
        c = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    // Flags are {running, expired, done, load_err}.
    task automatic step(input logic ld, input logic st, input logic pa, input logic [23:0] setv,
                        input logic [23:0] ed, input logic [3:0] ef, input string tag);
        exp_t e;
        logic [23:0] got_d;
        logic [3:0]  got_f;
        load  = ld;
        start = st;
        pause = pa;
        {set_hrm, set_hrl, set_minm, set_minl, set_secm, set_secl} = setv;
        sb.push_back('{tag, ed, ef});
        @(posedge clk_1hz);
        #1;
        e     = sb.pop_front();
        got_d = {hrm, hrl, minm, minl, secm, secl};
        got_f = {running, expired, done, load_err};
        n_assert++;
        assert (got_d === e.d) else begin
            n_fail++;
            $error("FAIL %s digits: got %h expected %h", e.tag, got_d, e.d);
        end
        n_assert++;
        assert (got_f === e.f) else begin
            n_fail++;
            $error("FAIL %s flags(run,exp,done,lerr): got %b expected %b", e.tag, got_f, e.f);
        end
    endtask

    initial begin
        rst = 1'b0;
        step(1, 1, 0, 24'h123456, 24'h000000, 4'b0000, "reset");
        rst = 1'b1;

        // 00:01:05 counts down in 65 edges, done pulses once
        step(1, 0, 0, 24'h000105, 24'h000105, 4'b0000, "load_105");
        step(0, 1, 0, 24'h0, 24'h000105, 4'b1000, "start_105");
        for (int i = 1; i <= 65; i++)
            step(0, 0, 0, 24'h0, bcd(65 - i), (i == 65) ? 4'b0110 : 4'b1000, "countdown");
        step(0, 0, 0, 24'h0, 24'h000000, 4'b0100, "done_one_cycle");
        step(0, 1, 1, 24'h0, 24'h000000, 4'b0100, "done_ignores_start");

        // Borrow chains across hour boundaries
        step(1, 0, 0, 24'h100000, 24'h100000, 4'b0000, "load_10h");
        step(0, 1, 0, 24'h0, 24'h100000, 4'b1000, "start_10h");
        step(0, 0, 0, 24'h0, 24'h095959, 4'b1000, "borrow_10h");
        step(1, 0, 0, 24'h010000, 24'h010000, 4'b0000, "load_in_run");
        step(0, 1, 0, 24'h0, 24'h010000, 4'b1000, "start_1h");
        step(0, 0, 0, 24'h0, 24'h005959, 4'b1000, "borrow_1h");

        // Rejected loads while running: no decrement, state kept
        step(1, 0, 0, 24'h006000, 24'h005959, 4'b1001, "bad_min");
        step(0, 0, 0, 24'h0, 24'h005958, 4'b1000, "after_bad_min");
        step(1, 0, 0, 24'h240000, 24'h005958, 4'b1001, "bad_hr");
        step(0, 0, 0, 24'h0, 24'h005957, 4'b1000, "after_bad_hr");

        // Pause held for 5 edges, pause+start acts as pause
        step(1, 0, 0, 24'h000030, 24'h000030, 4'b0000, "load_30");
        step(0, 1, 0, 24'h0, 24'h000030, 4'b1000, "start_30");
        for (int i = 0; i < 5; i++)
            step(0, i[0], 1, 24'h0, 24'h000030, 4'b0000, "pause_hold");
        step(0, 1, 0, 24'h0, 24'h000030, 4'b1000, "resume");
        step(0, 0, 0, 24'h0, 24'h000029, 4'b1000, "resume_dec");

        // Reset mid-run, then start on zero count is ignored
        step(1, 0, 0, 24'h123456, 24'h123456, 4'b0000, "load_12h");
        step(0, 1, 0, 24'h0, 24'h123456, 4'b1000, "start_12h");
        rst = 1'b0;
        step(0, 1, 0, 24'h0, 24'h000000, 4'b0000, "reset_mid_run");
        rst = 1'b1;
        step(0, 1, 0, 24'h0, 24'h000000, 4'b0000, "start_zero");
        step(0, 0, 0, 24'h0, 24'h000000, 4'b0000, "idle_zero");

        // load+start in RUN loads and idles without decrement
        step(1, 0, 0, 24'h123456, 24'h123456, 4'b0000, "load_12h_b");
        step(0, 1, 0, 24'h0, 24'h123456, 4'b1000, "start_12h_b");
        step(1, 1, 0, 24'h000010, 24'h000010, 4'b0000, "load_start_run");
        step(0, 0, 0, 24'h0, 24'h000010, 4'b0000, "no_retained_start");

        // Range boundaries
        step(1, 0, 0, 24'h235959, 24'h235959, 4'b0000, "load_max");
        step(1, 0, 0, 24'h23595A, 24'h235959, 4'b0001, "bad_secl");
        step(0, 0, 0, 24'h0, 24'h235959, 4'b0000, "lerr_one_cycle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001: Parameter HR_MAX, default 23, is the maximum loadable hour value, decimal.
REQ-002: clk_1hz  input  1  timer tick clock; all state updates occur on its rising edge.
REQ-003: rst  input  1  reset, synchronous, active-low.
REQ-004: load  input  1  capture set_* digits as the new count.
REQ-005: start  input  1  begin or resume counting down.
REQ-006: pause  input  1  suspend counting down.
REQ-007: set_hrm, set_hrl, set_minm, set_minl, set_secm, set_secl  input  4 each  BCD load value, HH:MM:SS.
REQ-008: hrm, hrl, minm, minl, secm, secl  output  4 each  current remaining time, BCD, registered.
REQ-009: running  output  1  high while in state RUN.
REQ-010: expired  output  1  high while in state DONE.
REQ-011: done  output  1  single-cycle pulse on reaching 00:00:00.
REQ-012: load_err  output  1  single-cycle pulse on a rejected load.

Function
REQ-013: The FSM SHALL have states IDLE, RUN, PAUSE and DONE, and all outputs SHALL be registered.
REQ-014: Input priority on each edge SHALL be: rst, then load, then pause, then start.
REQ-015: A load is valid only if set_secl<=9, set_secm<=5, set_minl<=9, set_minm<=5, set_hrl<=9, set_hrm<=2, and 10*set_hrm+set_hrl<=HR_MAX.
REQ-016: A valid load in any state SHALL copy set_* into the digits, enter IDLE, and clear expired in the same edge.
REQ-017: An invalid load SHALL leave the digits and state unchanged and pulse load_err high for exactly the next cycle.
REQ-018: start in IDLE with a nonzero count SHALL enter RUN; start in IDLE with count 00:00:00 SHALL be ignored.
REQ-019: The first decrement SHALL occur on the edge after the edge that entered RUN.
REQ-020: Each edge in RUN without pause or load SHALL decrement the count by one second.
REQ-021: The decrement borrow chain SHALL be:
  - secl 0->9, borrow to secm;
  - secm 0->5, borrow to minl;
  - minl 0->9, borrow to minm;
  - minm 0->5, borrow to hrl;
  - hrl 0->9, borrow to hrm;
  - other digits hold.
REQ-022: A decrement that produces 00:00:00 SHALL, on that same edge, enter DONE, set expired=1, running=0, and done=1 for one cycle.
REQ-023: In DONE the digits SHALL stay at 00:00:00; start and pause SHALL be ignored; only load or rst exits.
REQ-024: pause in RUN SHALL enter PAUSE with no decrement on that edge; pause in any other state is ignored.
REQ-025: start without pause in PAUSE SHALL return to RUN, and decrementing SHALL resume on the following edge.
REQ-026: pause and start asserted together SHALL behave as pause alone.
REQ-027: The digits SHALL never leave their BCD ranges.
REQ-028: The count SHALL never decrement below 00:00:00 or wrap around.

Reset
REQ-029: When rst=0 at an edge, all digits SHALL become 0, state SHALL become IDLE, and running, expired, done and load_err SHALL all be 0, regardless of the other inputs.
REQ-030: Reset asserted mid-RUN or mid-load SHALL discard the operation in progress; after rst releases, no start SHALL be retained.

Verification
REQ-031: Load 00:01:05, then pulse start -> 65 decrement edges later the count reads 00:00:00, done is high for exactly 1 cycle, expired=1, running=0.
REQ-032: Load 10:00:00, start, then one decrement edge -> 09:59:59; load 01:00:00 with one decrement -> 00:59:59.
REQ-033: Load 00:60:00 or 24:00:00 with HR_MAX=23 -> load_err pulses for 1 cycle, digits unchanged, state unchanged.
REQ-034: Running at 00:00:30, hold pause for 5 edges -> digits stay 00:00:30 and running=0; then start -> 00:00:29 one edge after re-entering RUN.
REQ-035: rst=0 during RUN at 12:34:56 -> next cycle all digits 0, IDLE, all flags 0; start with count 00:00:00 -> stays IDLE, done never pulses.
REQ-036: load and start together in RUN -> the new value is loaded, the state is IDLE, and there is no decrement on that edge.
